// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common command bytes
// and the odd-parity helper used when loading a frame.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  // PS/2 parity is odd: the bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data lines, plus a
// falling-edge strobe on the clock line. Shared with the keyboard receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta, clk_q, clk_prev;
  logic data_meta, data_q;

  // Idle lines are pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_q     <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_q    <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_q     <= clk_meta;
      clk_prev  <= clk_q;
      data_meta <= ps2_data;
      data_q    <= data_meta;
    end
  end

  assign clk_sync  = clk_q;
  assign data_sync = data_q;
  assign clk_fall  = clk_prev & ~clk_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift
// out data/parity/stop on device clock falls, then sample the device ACK.
// Handshake: a byte transfers on any cycle where tx_valid and tx_ready are
// both high; tx_data is only looked at in that cycle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout
);

  localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s, data_s, clk_fall;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_sync  (clk_s),
    .data_sync (data_s),
    .clk_fall  (clk_fall)
  );

  ps2_tx_state_t state_q, state_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic          timeout_q, timeout_d;
  logic          ack_q, ack_d;
  logic          to_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      inh_q     <= '0;
      to_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
    end
  end

  // A device edge in the expiry cycle wins, so expiry is only acted on
  // in branches where clk_fall is low.
  assign to_expired = (to_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    inh_d     = inh_q;
    to_d      = to_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    ack_d     = ack_q;
    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d = {ps2_odd_parity(tx_data), tx_data};
          inh_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == INH_LAST) begin
          state_d   = START;
          data_oe_d = 1'b1;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      START: begin
        state_d  = SHIFT;
        bitcnt_d = '0;
        to_d     = '0;
      end
      SHIFT: begin
        if (clk_fall) begin
          to_d     = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end
        end else if (to_expired) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          nack_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ACK: begin
        if (clk_fall) begin
          to_d    = '0;
          ack_d   = data_s;
          state_d = WAIT_IDLE;
        end else if (to_expired) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          nack_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // nack is published only with done so it holds until the next one.
        if (clk_s && data_s) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          nack_d    = ack_q;
          timeout_d = 1'b0;
        end else if (clk_fall) begin
          to_d = '0;
        end else if (to_expired) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          nack_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
    endcase
    clk_oe_d = (state_d == INHIBIT) || (state_d == START);
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == IDLE);
  assign busy        = ~tx_ready;
  assign done        = done_q;
  assign nack        = nack_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model with a clocking PS/2 device,
// frame and result scoreboards, reset/timeout/back-to-back scenarios.
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TMO = 100;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       dev_clk, dev_data;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, done, nack, timeout;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .nack        (nack),
    .timeout     (timeout)
  );

  // Clock/reset and wired-AND open-drain lines.
  always #5 clk = ~clk;
  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int oe_run = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int last_fall_cyc = 0;

  logic [10:0] exp_q[$];
  logic [1:0]  res_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) oe_run <= ps2_clk_oe ? oe_run + 1 : 0;

  // Result scoreboard: every done pulse must match a queued {nack, timeout}.
  always @(posedge clk) begin
    #1;
    if (done) begin
      logic [1:0] r;
      done_cnt++;
      last_done_cyc = cyc;
      chk("done_tx_ready", tx_ready, 1);
      chk("done_expected", res_q.size() > 0, 1);
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        chk("nack", nack, r[1]);
        chk("timeout", timeout, r[0]);
      end
    end
  end

  task automatic start_tx(input logic [7:0] b);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    chk("ready_wait", ok, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("accept_busy", busy, 1);
  endtask

  // Device side: wait for the host's inhibit + request-to-send.
  task automatic dev_wait_rts();
    bit seen_low = 0;
    bit seen_rel = 0;
    for (int i = 0; i < 100; i++) begin
      if (ps2_clk_oe) begin seen_low = 1; break; end
      @(negedge clk);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe) begin seen_rel = 1; break; end
    end
    chk("rts_seen", {seen_low, seen_rel}, 2'b11);
    chk("clk_oe_cycles", oe_run, INH + 1);
    chk("start_bit_drive", ps2_data_oe, 1);
  endtask

  // Device generates nclk clocks, sampling the data line late in each high
  // phase (start, d0..d7, parity, stop) and optionally ACKing on clock 11.
  task automatic dev_clock(input int nclk, input bit ack, output logic [10:0] got);
    got = '0;
    for (int i = 0; i < nclk; i++) begin
      repeat (HALF / 2) @(negedge clk);
      if (i < 11) got[i] = ps2_data;
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget);
    int s = done_cnt;
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != s) begin seen = 1; break; end
    end
    chk("done_wait", seen, 1);
  endtask

  task automatic full_xfer(input logic [7:0] b, input bit dev_ack);
    logic [10:0] got, f;
    exp_q.push_back({1'b1, ~^b, b, 1'b0});
    res_q.push_back({~dev_ack, 1'b0});
    start_tx(b);
    dev_wait_rts();
    dev_clock(11, dev_ack, got);
    f = exp_q.pop_front();
    chk("frame", got, f);
    wait_done(200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] got, f;
    int s;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {nack, timeout}, 2'b00);

    // Normal frames including parity boundaries, then a missing ACK.
    full_xfer(8'hED, 1'b1);
    full_xfer(8'h00, 1'b1);
    full_xfer(8'h01, 1'b1);
    full_xfer(8'hAB, 1'b0);

    // Device stalls after four clocks: raw edge + 3-cycle detect + 100 cycles.
    res_q.push_back(2'b11);
    start_tx(8'h5A);
    dev_wait_rts();
    dev_clock(4, 1'b0, got);
    wait_done(300);
    chk("timeout_latency", last_done_cyc - last_fall_cyc, 103);
    chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    chk("timeout_ready", tx_ready, 1);

    // Reset in the middle of the data bits.
    start_tx(8'h3C);
    dev_wait_rts();
    dev_clock(5, 1'b0, got);
    s = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", tx_ready, 1);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt - s, 0);
    full_xfer(8'hFF, 1'b1);

    // Back-to-back with tx_valid held; tx_data changes while busy.
    s = done_cnt;
    exp_q.push_back({1'b1, ~^8'hF4, 8'hF4, 1'b0});
    exp_q.push_back({1'b1, ~^8'hF5, 8'hF5, 1'b0});
    res_q.push_back(2'b00);
    res_q.push_back(2'b00);
    tx_valid = 1'b1;
    tx_data  = 8'hF4;
    @(negedge clk);
    tx_data  = 8'hF5;
    dev_wait_rts();
    dev_clock(11, 1'b1, got);
    f = exp_q.pop_front();
    chk("b2b_frame0", got, f);
    wait_done(200);
    @(negedge clk);
    chk("b2b_accept", busy, 1);
    tx_valid = 1'b0;
    dev_wait_rts();
    dev_clock(11, 1'b1, got);
    f = exp_q.pop_front();
    chk("b2b_frame1", got, f);
    wait_done(200);
    repeat (60) @(negedge clk);
    chk("b2b_done_count", done_cnt - s, 2);
    chk("b2b_idle", busy, 0);
    chk("sb_empty", exp_q.size() + res_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
